// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared FSM state encoding and AXI response codes for the AXI4-Lite-to-APB bridge.
package apb_bridge_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: ACCESS-phase watchdog; expire_o pulses on the CYCLES-th enabled cycle after a clear.
module apb_timeout_cnt #(
  parameter int CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end
  assign expire_o = en_i && cnt_q == W'(CYCLES - 1);
endmodule

// File: rtl/axil_apb_ctrl.sv
// axil_apb_ctrl: AXI4-Lite slave front end that sequences APB SETUP/ACCESS and returns B/R responses.
// Optional ACCESS-phase abort is enabled by defining APB_TIMEOUT_EN.
module axil_apb_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int DATAWIDTH      = 32,
  parameter int ADDRWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [ADDRWIDTH-1:0]   awaddr,
  input  logic [2:0]             awprot,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [DATAWIDTH-1:0]   wdata,
  input  logic [DATAWIDTH/8-1:0] wstrb,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [ADDRWIDTH-1:0]   araddr,
  input  logic [2:0]             arprot,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [DATAWIDTH-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   pselxM,
  output logic                   penableM,
  output logic                   pwriteM,
  output logic [ADDRWIDTH-1:0]   paddrM,
  output logic [DATAWIDTH-1:0]   pwdataM,
  output logic [DATAWIDTH/8-1:0] pstrbM,
  output logic [2:0]             pprotM,
  input  logic                   preadyM,
  input  logic                   pslverrM,
  input  logic [DATAWIDTH-1:0]   prdataM
);
  localparam int SW = DATAWIDTH / 8;
  state_e               state_q;
  logic                 aw_held_q, w_held_q, ar_held_q, last_rd_q;
  logic [ADDRWIDTH-1:0] awaddr_q, araddr_q;
  logic [2:0]           awprot_q, arprot_q;
  logic [DATAWIDTH-1:0] wdata_q, rdata_q, pwdata_q;
  logic [SW-1:0]        wstrb_q, pstrb_q;
  logic                 bvalid_q, rvalid_q, psel_q, penable_q, pwrite_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [ADDRWIDTH-1:0] paddr_q;
  logic [2:0]           pprot_q;
  logic                 wr_go_d, rd_go_d, done_d, err_d, tmo;
  // A conflict goes to the direction not served last; a lone eligible request always goes.
  assign wr_go_d = aw_held_q && w_held_q && (!ar_held_q || last_rd_q);
  assign rd_go_d = ar_held_q && !wr_go_d;
  assign done_d  = state_q == ACCESS && (preadyM || tmo);
  assign err_d   = !preadyM || pslverrM;
`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(.CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q == SETUP),
    .en_i     (state_q == ACCESS),
    .expire_o (tmo)
  );
`else
  logic unused_cfg;
  assign tmo        = 1'b0;
  assign unused_cfg = |TIMEOUT_CYCLES;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      last_rd_q <= 1'b1;
      awaddr_q  <= '0;
      awprot_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      arprot_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
    end else begin
      if (awvalid && !aw_held_q) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= awaddr;
        awprot_q  <= awprot;
      end
      if (wvalid && !w_held_q) begin
        w_held_q <= 1'b1;
        wdata_q  <= wdata;
        wstrb_q  <= wstrb;
      end
      if (arvalid && !ar_held_q) begin
        ar_held_q <= 1'b1;
        araddr_q  <= araddr;
        arprot_q  <= arprot;
      end
      case (state_q)
        IDLE: if (wr_go_d || rd_go_d) begin
          state_q   <= SETUP;
          psel_q    <= 1'b1;
          pwrite_q  <= wr_go_d;
          paddr_q   <= wr_go_d ? awaddr_q : araddr_q;
          pprot_q   <= wr_go_d ? awprot_q : arprot_q;
          pwdata_q  <= wr_go_d ? wdata_q : '0;
          pstrb_q   <= wr_go_d ? wstrb_q : '0;
          last_rd_q <= rd_go_d;
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: if (done_d) begin
          state_q   <= RESP;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          if (pwrite_q) begin
            bvalid_q  <= 1'b1;
            bresp_q   <= err_d ? RESP_SLVERR : RESP_OKAY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
          end else begin
            rvalid_q  <= 1'b1;
            rresp_q   <= err_d ? RESP_SLVERR : RESP_OKAY;
            rdata_q   <= preadyM ? prdataM : '0;
            ar_held_q <= 1'b0;
          end
        end
        RESP: if ((bvalid_q && bready) || (rvalid_q && rready)) begin
          state_q  <= IDLE;
          bvalid_q <= 1'b0;
          rvalid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign awready  = !aw_held_q;
  assign wready   = !w_held_q;
  assign arready  = !ar_held_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;
  assign pselxM   = psel_q;
  assign penableM = penable_q;
  assign pwriteM  = pwrite_q;
  assign paddrM   = paddr_q;
  assign pwdataM  = pwdata_q;
  assign pstrbM   = pstrb_q;
  assign pprotM   = pprot_q;
endmodule

// File: tb/tb_axil_apb_ctrl.sv
// tb_axil_apb_ctrl: scoreboard bench for axil_apb_ctrl; define APB_TIMEOUT_EN to also cover the abort path.
module tb_axil_apb_ctrl;
  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } ap_t;
  logic clk = 0, rst_n = 0;
  logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
  logic awready, wready, arready, bvalid, rvalid;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic [1:0] bresp, rresp;
  logic pselxM, penableM, pwriteM, preadyM = 0, pslverrM = 0;
  logic [31:0] paddrM, pwdataM, prdataM = 0;
  logic [3:0] pstrbM;
  logic [2:0] pprotM;
  int n_cmp = 0, n_err = 0, n_rsp = 0;
  int wait_states = 0, acc_n = 0, acc_len = 0;
  bit no_ready = 0;
  rsp_t exp_rsp[$];
  ap_t  exp_apb[$];
  rsp_t er;
  ap_t  ea;
  axil_apb_ctrl #(.DATAWIDTH(32), .ADDRWIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .pselxM(pselxM), .penableM(penableM), .pwriteM(pwriteM), .paddrM(paddrM),
    .pwdataM(pwdataM), .pstrbM(pstrbM), .pprotM(pprotM),
    .preadyM(preadyM), .pslverrM(pslverrM), .prdataM(prdataM)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  // APB completer model: pready on the ACCESS cycle after wait_states stalls.
  always @(negedge clk) begin
    if (pselxM && penableM) begin
      preadyM = !no_ready && acc_n == wait_states;
      acc_n++;
      acc_len = acc_n;
    end else begin
      preadyM = 0;
      acc_n = 0;
    end
  end
  always @(negedge clk) begin
    if (rst_n && pselxM && !penableM) begin
      n_cmp++;
      if (exp_apb.size() == 0) begin
        n_err++;
        $display("FAIL apb_setup: unexpected SETUP wr=%b addr=%h", pwriteM, paddrM);
      end else begin
        ea = exp_apb.pop_front();
        if ({pwriteM, paddrM, pwdataM, pstrbM, pprotM} !== {ea.wr, ea.addr, ea.wdata, ea.strb, ea.prot}) begin
          n_err++;
          $display("FAIL apb_setup: got wr=%b addr=%h wdata=%h strb=%h prot=%b, want wr=%b addr=%h wdata=%h strb=%h prot=%b",
                   pwriteM, paddrM, pwdataM, pstrbM, pprotM, ea.wr, ea.addr, ea.wdata, ea.strb, ea.prot);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (bvalid && bready || rvalid && rready) begin
      n_cmp++;
      n_rsp++;
      if (exp_rsp.size() == 0) begin
        n_err++;
        $display("FAIL response: unexpected bvalid=%b rvalid=%b", bvalid, rvalid);
      end else begin
        er = exp_rsp.pop_front();
        if (bvalid && ({1'b1, bresp, rvalid} !== {er.wr, er.resp, 1'b0})) begin
          n_err++;
          $display("FAIL b_resp: got bresp=%b rvalid=%b, want wr=%b resp=%b", bresp, rvalid, er.wr, er.resp);
        end
        if (rvalid && ({1'b0, rresp, rdata, bvalid} !== {er.wr, er.resp, er.data, 1'b0})) begin
          n_err++;
          $display("FAIL r_resp: got rresp=%b rdata=%h bvalid=%b, want wr=%b resp=%b rdata=%h",
                   rresp, rdata, bvalid, er.wr, er.resp, er.data);
        end
      end
    end
  end
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    exp_apb.push_back('{1'b1, a, d, s, 3'b001});
    exp_rsp.push_back('{1'b1, 32'h0, r});
  endtask
  task automatic push_rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    exp_apb.push_back('{1'b0, a, 32'h0, 4'h0, 3'b010});
    exp_rsp.push_back('{1'b0, d, r});
  endtask
  task automatic issue(input bit a, input bit w, input bit r, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ra);
    awvalid = a; awaddr = wa; awprot = 3'b001;
    wvalid = w; wdata = wd; wstrb = ws;
    arvalid = r; araddr = ra; arprot = 3'b010;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
  endtask
  task automatic wait_rsp(input int tgt);
    for (int i = 0; i < 200 && n_rsp < tgt; i++) @(negedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== {3'b111, 2'b00, 4'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_axi: got rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h, want 111 0 0 00 00 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
    end
    n_cmp++;
    if ({pselxM, penableM, pwriteM, paddrM, pwdataM, pstrbM, pprotM} !== '0) begin
      n_err++;
      $display("FAIL reset_apb: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h pprot=%b, want all 0",
               pselxM, penableM, pwriteM, paddrM, pwdataM, pstrbM, pprotM);
    end
  endtask
  task automatic test_write();
    int base = n_rsp;
    wait_states = 0; pslverrM = 0;
    push_wr(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    issue(1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    n_cmp++;
    if ({awready, wready, pselxM} !== 3'b000) begin
      n_err++;
      $display("FAIL write_t1: got awready=%b wready=%b psel=%b, want 0 0 0", awready, wready, pselxM);
    end
    @(negedge clk);
    n_cmp++;
    if ({pselxM, penableM, pwriteM, paddrM, pstrbM} !== {3'b101, 32'h10, 4'hF}) begin
      n_err++;
      $display("FAIL write_setup: got psel=%b pen=%b pwr=%b paddr=%h pstrb=%h, want 1 0 1 10 f",
               pselxM, penableM, pwriteM, paddrM, pstrbM);
    end
    @(negedge clk);
    n_cmp++;
    if ({pselxM, penableM, bvalid} !== 3'b110) begin
      n_err++;
      $display("FAIL write_access: got psel=%b pen=%b bvalid=%b, want 1 1 0", pselxM, penableM, bvalid);
    end
    @(negedge clk);
    n_cmp++;
    if ({bvalid, bresp, pselxM, awready, wready} !== 6'b100011) begin
      n_err++;
      $display("FAIL write_t4: got bvalid=%b bresp=%b psel=%b awready=%b wready=%b, want 1 00 0 1 1",
               bvalid, bresp, pselxM, awready, wready);
    end
    wait_rsp(base + 1);
    n_cmp++;
    if (n_rsp !== base + 1) begin
      n_err++;
      $display("FAIL write_done: got %0d responses, want %0d", n_rsp - base, 1);
    end
  endtask
  task automatic test_read();
    int base = n_rsp;
    wait_states = 3; pslverrM = 1; prdataM = 32'h12345678;
    push_rd(32'h20, 32'h12345678, 2'b10);
    issue(0, 0, 1, 0, 0, 0, 32'h20);
    wait_rsp(base + 1);
    n_cmp++;
    if (n_rsp !== base + 1 || acc_len !== 4) begin
      n_err++;
      $display("FAIL read_wait: got responses=%0d access_cycles=%0d, want 1 4", n_rsp - base, acc_len);
    end
    wait_states = 0; pslverrM = 0;
  endtask
  task automatic test_arbitration();
    int base;
    do_reset();
    base = n_rsp;
    prdataM = 32'hCAFE0008;
    push_wr(32'h4, 32'hA5A50004, 4'hF, 2'b00);
    push_rd(32'h8, 32'hCAFE0008, 2'b00);
    issue(1, 1, 1, 32'h4, 32'hA5A50004, 4'hF, 32'h8);
    wait_rsp(base + 2);
    push_wr(32'h4, 32'h0000BEEF, 4'h1, 2'b00);
    push_rd(32'h8, 32'hCAFE0008, 2'b00);
    issue(1, 1, 1, 32'h4, 32'h0000BEEF, 4'h1, 32'h8);
    wait_rsp(base + 4);
    push_wr(32'hC, 32'h0C0C0C0C, 4'hF, 2'b00);
    issue(1, 1, 0, 32'hC, 32'h0C0C0C0C, 4'hF, 0);
    wait_rsp(base + 5);
    push_rd(32'h8, 32'hCAFE0008, 2'b00);
    push_wr(32'h4, 32'h44444444, 4'hF, 2'b00);
    issue(1, 1, 1, 32'h4, 32'h44444444, 4'hF, 32'h8);
    wait_rsp(base + 7);
    n_cmp++;
    if (n_rsp !== base + 7 || exp_apb.size() !== 0) begin
      n_err++;
      $display("FAIL arb_count: got responses=%0d leftover_setups=%0d, want 7 0", n_rsp - base, exp_apb.size());
    end
  endtask
  task automatic test_w_first();
    int base = n_rsp;
    bit early = 0;
    push_wr(32'h30, 32'h11112222, 4'h3, 2'b00);
    issue(0, 1, 0, 0, 32'h11112222, 4'h3, 0);
    n_cmp++;
    if ({wready, awready} !== 2'b01) begin
      n_err++;
      $display("FAIL w_first_rdy: got wready=%b awready=%b, want 0 1", wready, awready);
    end
    repeat (4) begin
      @(negedge clk);
      if (pselxM) early = 1;
    end
    n_cmp++;
    if (early !== 0) begin
      n_err++;
      $display("FAIL w_first_wait: got psel while only W held, want no SETUP");
    end
    issue(1, 0, 0, 32'h30, 0, 0, 0);
    wait_rsp(base + 1);
    n_cmp++;
    if (n_rsp !== base + 1) begin
      n_err++;
      $display("FAIL w_first_done: got %0d responses, want 1", n_rsp - base);
    end
  endtask
  task automatic test_aw_only();
    int base = n_rsp;
    prdataM = 32'h0BADF00D;
    push_rd(32'h44, 32'h0BADF00D, 2'b00);
    push_wr(32'h40, 32'h55667788, 4'hC, 2'b00);
    issue(1, 0, 0, 32'h40, 0, 0, 0);
    issue(0, 0, 1, 0, 0, 0, 32'h44);
    wait_rsp(base + 1);
    n_cmp++;
    if ({n_rsp == base + 1, awready, wready} !== 3'b101) begin
      n_err++;
      $display("FAIL aw_only_read: got responses=%0d awready=%b wready=%b, want 1 0 1", n_rsp - base, awready, wready);
    end
    issue(0, 1, 0, 0, 32'h55667788, 4'hC, 0);
    wait_rsp(base + 2);
    n_cmp++;
    if (n_rsp !== base + 2) begin
      n_err++;
      $display("FAIL aw_only_write: got %0d responses, want 2", n_rsp - base);
    end
  endtask
  task automatic test_back_to_back();
    int base = n_rsp;
    bit bad = 0;
    wait_states = 1; pslverrM = 1; prdataM = 32'h77778888;
    bready = 0;
    push_wr(32'h50, 32'h00000099, 4'hF, 2'b10);
    push_rd(32'h54, 32'h77778888, 2'b10);
    issue(1, 1, 0, 32'h50, 32'h00000099, 4'hF, 0);
    for (int i = 0; i < 20 && !bvalid; i++) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      if (!bvalid || bresp !== 2'b10 || rvalid) bad = 1;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL b_stall: got bvalid=%b bresp=%b rvalid=%b, want stable 1 10 0", bvalid, bresp, rvalid);
    end
    issue(0, 0, 1, 0, 0, 0, 32'h54);
    n_cmp++;
    if ({arready, pselxM, awready, wready} !== 4'b0011) begin
      n_err++;
      $display("FAIL b2b_capture: got arready=%b psel=%b awready=%b wready=%b, want 0 0 1 1",
               arready, pselxM, awready, wready);
    end
    bready = 1;
    wait_rsp(base + 2);
    n_cmp++;
    if (n_rsp !== base + 2) begin
      n_err++;
      $display("FAIL b2b_done: got %0d responses, want 2", n_rsp - base);
    end
    wait_states = 0; pslverrM = 0;
  endtask
  task automatic test_reset_mid();
    int base = n_rsp;
    bit seen = 0, leak = 0;
    no_ready = 1;
    exp_apb.push_back('{1'b0, 32'h60, 32'h0, 4'h0, 3'b010});
    issue(0, 0, 1, 0, 0, 0, 32'h60);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pselxM && penableM;
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    n_cmp++;
    if ({seen, pselxM, penableM, awready, wready, arready, bvalid, rvalid, paddrM} !== {1'b1, 2'b00, 3'b111, 2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL reset_mid: got seen=%b psel=%b pen=%b rdy=%b%b%b bv=%b rv=%b paddr=%h, want 1 0 0 111 0 0 0",
               seen, pselxM, penableM, awready, wready, arready, bvalid, rvalid, paddrM);
    end
    @(negedge clk);
    rst_n = 1;
    no_ready = 0;
    repeat (10) begin
      @(negedge clk);
      if (bvalid || rvalid || pselxM) leak = 1;
    end
    n_cmp++;
    if (leak !== 0 || n_rsp !== base) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got activity after reset, responses=%0d, want none", n_rsp - base);
    end
    push_wr(32'h64, 32'h600DF00D, 4'hF, 2'b00);
    issue(1, 1, 0, 32'h64, 32'h600DF00D, 4'hF, 0);
    wait_rsp(base + 1);
    n_cmp++;
    if (n_rsp !== base + 1) begin
      n_err++;
      $display("FAIL reset_mid_recover: got %0d responses, want 1", n_rsp - base);
    end
  endtask
`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int base = n_rsp;
    no_ready = 1;
    push_wr(32'h70, 32'h00001234, 4'hF, 2'b10);
    issue(1, 1, 0, 32'h70, 32'h00001234, 4'hF, 0);
    wait_rsp(base + 1);
    n_cmp++;
    if ({n_rsp == base + 1, pselxM, awready, wready} !== 4'b1011 || acc_len !== 8) begin
      n_err++;
      $display("FAIL timeout: got responses=%0d access_cycles=%0d psel=%b awready=%b wready=%b, want 1 8 0 1 1",
               n_rsp - base, acc_len, pselxM, awready, wready);
    end
    no_ready = 0;
    prdataM = 32'h0000ABCD;
    push_rd(32'h74, 32'h0000ABCD, 2'b00);
    issue(0, 0, 1, 0, 0, 0, 32'h74);
    wait_rsp(base + 2);
    n_cmp++;
    if (n_rsp !== base + 2) begin
      n_err++;
      $display("FAIL timeout_recover: got %0d responses, want 2", n_rsp - base);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_w_first();
    test_aw_only();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (exp_rsp.size() !== 0 || exp_apb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d responses and %0d setups outstanding, want 0 0", exp_rsp.size(), exp_apb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
